// File: rtl/frame_buffer_scheduler.sv
// Double-buffered LED frame store: host fills the back bank, commit swaps
// banks on a scan-frame boundary, then the new front is copied to the back.
module frame_buffer_scheduler #(
    parameter int NUM_ROWS     = 16,
    parameter int LEDS_PER_ROW = 16,
    parameter int COLOR_BITS   = 8,
    localparam int RW    = $clog2(NUM_ROWS),
    localparam int LW    = $clog2(LEDS_PER_ROW),
    localparam int CW    = 3 * COLOR_BITS,
    localparam int ROW_W = LEDS_PER_ROW * CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [RW-1:0]    scan_row,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [RW-1:0]    wr_row,
    input  logic [LW-1:0]    wr_led,
    input  logic [CW-1:0]    wr_rgb,
    input  logic             commit,
    output logic             swap_pending,
    output logic             swap_done,
    output logic [ROW_W-1:0] row_colors
);

    typedef enum logic [1:0] {
        INIT,
        FILL,
        PEND,
        COPY
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_done_q, swap_done_d;
    logic [ROW_W-1:0] row_colors_q;

    logic [ROW_W-1:0] bank_q [2][NUM_ROWS];

    logic        back_sel;
    logic        in_range;
    logic        init_en;
    logic        copy_en;
    logic        wr_en;
    int unsigned led_lsb;

    assign back_sel = ~front_sel_q;
    assign in_range = (int'(wr_row) < NUM_ROWS) && (int'(wr_led) < LEDS_PER_ROW);
    // LED 0 lives in the most significant slice of the row word
    assign led_lsb  = (LEDS_PER_ROW - 1 - int'(wr_led)) * CW;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        front_sel_d  = front_sel_q;
        swap_done_d  = 1'b0;
        wr_ready     = 1'b0;
        swap_pending = 1'b0;
        init_en      = 1'b0;
        copy_en      = 1'b0;
        wr_en        = 1'b0;
        unique case (state_q)
            INIT: begin
                init_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == RW'(NUM_ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                wr_ready = 1'b1;
                wr_en    = wr_valid && in_range;
                if (commit) state_d = PEND;
            end
            PEND: begin
                swap_pending = 1'b1;
                if (frame_start) begin
                    front_sel_d = ~front_sel_q;
                    swap_done_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = COPY;
                end
            end
            COPY: begin
                copy_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == RW'(NUM_ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            front_sel_q  <= 1'b0;
            swap_done_q  <= 1'b0;
            row_colors_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            front_sel_q <= front_sel_d;
            swap_done_q <= swap_done_d;
            if (state_q == INIT) row_colors_q <= '0;
            else row_colors_q <= bank_q[front_sel_q][scan_row];
        end
    end

    always_ff @(posedge clk) begin
        if (init_en) begin
            bank_q[0][cnt_q] <= '0;
            bank_q[1][cnt_q] <= '0;
        end
        if (copy_en) bank_q[back_sel][cnt_q] <= bank_q[front_sel_q][cnt_q];
        if (wr_en) bank_q[back_sel][wr_row][led_lsb +: CW] <= wr_rgb;
    end

    assign swap_done  = swap_done_q;
    assign row_colors = row_colors_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios plus random traffic
// checked every cycle against a bank-level reference model.
module tb_frame_buffer_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic         frame_start;
    logic [3:0]   scan_row;
    logic         wr_valid;
    logic         wr_ready;
    logic [3:0]   wr_row;
    logic [3:0]   wr_led;
    logic [23:0]  wr_rgb;
    logic         commit;
    logic         swap_pending;
    logic         swap_done;
    logic [383:0] row_colors;

    always #5 clk = ~clk;

    frame_buffer_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .scan_row     (scan_row),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_led       (wr_led),
        .wr_rgb       (wr_rgb),
        .commit       (commit),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .row_colors   (row_colors)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: LED values per bank/row/led, plus busy-time bookkeeping
    logic [23:0] m_led [2][16][16];
    int          m_front;
    bit          m_pend;
    int          m_init;
    int          m_copy;

    task automatic chk(input string tag, input logic [383:0] obs,
                       input logic [383:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [383:0] row_of(input int b, input int r);
        logic [383:0] v = '0;
        for (int n = 0; n < 16; n++) v[(15 - n) * 24 +: 24] = m_led[b][r][n];
        return v;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 16; r++)
                for (int n = 0; n < 16; n++) m_led[b][r][n] = '0;
        m_front = 0;
        m_pend  = 1'b0;
        m_init  = 16;
        m_copy  = 0;
    endtask

    task automatic idle();
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        commit      = 1'b0;
    endtask

    task automatic tick();
        bit           rdy;
        bit           e_sd;
        logic [383:0] e_rc;
        rdy  = (m_init == 0) && !m_pend && (m_copy == 0);
        e_rc = (m_init > 0) ? '0 : row_of(m_front, int'(scan_row));
        e_sd = 1'b0;
        if (m_init > 0) m_init--;
        else if (m_copy > 0) m_copy--;
        else if (rdy) begin
            if (wr_valid) m_led[1 - m_front][wr_row][wr_led] = wr_rgb;
            if (commit) m_pend = 1'b1;
        end else if (m_pend && frame_start) begin
            m_front = 1 - m_front;
            for (int r = 0; r < 16; r++)
                for (int n = 0; n < 16; n++)
                    m_led[1 - m_front][r][n] = m_led[m_front][r][n];
            m_pend = 1'b0;
            m_copy = 16;
            e_sd   = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("wr_ready", wr_ready,
            (m_init == 0) && !m_pend && (m_copy == 0));
        chk("swap_pending", swap_pending, m_pend);
        chk("swap_done", swap_done, e_sd);
        chk("row_colors", row_colors, e_rc);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 1'b0);
        chk({tag, "_swap_pending"}, swap_pending, 1'b0);
        chk({tag, "_swap_done"}, swap_done, 1'b0);
        chk({tag, "_row_colors"}, row_colors, '0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        idle();
        model_reset();
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input int r, input int n, input logic [23:0] rgb);
        wr_valid = 1'b1;
        wr_row   = 4'(r);
        wr_led   = 4'(n);
        wr_rgb   = rgb;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic swap_now();
        commit = 1'b1;
        tick();
        commit      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (17) tick();
    endtask

    task automatic sweep();
        for (int r = 0; r < 16; r++) begin
            scan_row = 4'(r);
            tick();
        end
        tick();
    endtask

    initial begin
        int waited;
        logic [383:0] exp_row;
        reset    = 1'b1;
        scan_row = '0;
        wr_row   = '0;
        wr_led   = '0;
        wr_rgb   = '0;
        idle();
        @(negedge clk);
        do_reset("rst0");

        // INIT: 16 busy cycles, zero display for every row
        sweep();

        // Single write, commit, swap
        scan_row = 4'd3;
        wr(3, 0, 24'hFF0000);
        swap_now();
        exp_row = '0;
        exp_row[383:360] = 24'hFF0000;
        chk("t2_row3", row_colors, exp_row);

        // Partial update keeps the earlier LED
        wr(3, 15, 24'h0000FF);
        swap_now();
        exp_row[23:0] = 24'h0000FF;
        chk("t3_row3", row_colors, exp_row);

        // commit with frame_start in the same cycle, then a redundant commit
        wr(7, 4, 24'hA5A5A5);
        scan_row    = 4'd7;
        commit      = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        tick();
        commit = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (17) tick();

        // Write held through PEND and COPY is taken only once FILL returns
        commit = 1'b1;
        tick();
        commit   = 1'b0;
        wr_valid = 1'b1;
        wr_row   = 4'd5;
        wr_led   = 4'd7;
        wr_rgb   = 24'h123456;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        waited = 0;
        while (!wr_ready && waited < 40) begin
            tick();
            waited++;
        end
        chk("t5_ready_timeout", (waited < 40), 1'b1);
        tick();
        wr_valid = 1'b0;
        scan_row = 4'd5;
        swap_now();
        exp_row = '0;
        exp_row[(15 - 7) * 24 +: 24] = 24'h123456;
        chk("t5_row5", row_colors, exp_row);

        // Reset in the middle of COPY
        wr(9, 2, 24'h00FF00);
        commit = 1'b1;
        tick();
        commit      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (7) tick();
        do_reset("rst_copy");
        sweep();
        swap_now();
        sweep();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset("rst_rand");
            scan_row    = 4'($urandom_range(0, 15));
            wr_valid    = ($urandom_range(0, 1) == 1);
            wr_row      = 4'($urandom_range(0, 15));
            wr_led      = 4'($urandom_range(0, 15));
            wr_rgb      = 24'($urandom);
            commit      = ($urandom_range(0, 19) == 0);
            frame_start = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
